main_mem_model: RTL and testbench



---
 rtl/cache_bus_pkg.sv | 38 +++
 rtl/main_mem_model_if.sv | 45 ++++
 rtl/main_mem_array.sv | 44 ++++
 rtl/main_mem_model.sv | 127 ++++++++++++
 tb/tb_main_mem_model.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache lab buses.
// C1 is the CPU<->cache bus, C2 is the cache<->main-memory bus.
// Holds command encodings, default geometry and the main-memory FSM state type.
package cache_bus_pkg;

    localparam int unsigned DEFAULT_BUS_SIZE          = 16;
    localparam int unsigned DEFAULT_MEM_ADDR_SIZE     = 19;
    localparam int unsigned DEFAULT_CACHE_OFFSET_SIZE = 4;
    localparam int unsigned DEFAULT_CACHE_LINE_SIZE   = 16;

    typedef enum logic [2:0] {
        C1Nop         = 3'd0,
        C1Read8       = 3'd1,
        C1Read16      = 3'd2,
        C1Read32      = 3'd3,
        C1InvLine     = 3'd4,
        C1Write8      = 3'd5,
        C1Write16     = 3'd6,
        C1Write32Resp = 3'd7
    } c1_cmd_e;

    typedef enum logic [1:0] {
        C2Nop      = 2'd0,
        C2Response = 2'd1,
        C2Read     = 2'd2,
        C2Write    = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdBurst,
        StWrData,
        StWrWait,
        StWrResp
    } mem_state_e;

endpackage

// File: rtl/main_mem_model_if.sv
// C2 bus between the L1 cache (master) and main memory (slave).
// mem_data / mem_command are shared tri-state nets. Each side supplies a value and an
// output enable; the nets are resolved here so both drivers sit in one scope.
//   mem_address  : line address from the cache
//   mem_data     : shared data bus
//   mem_command  : shared command bus (c2_cmd_e encoding)
//   busy         : memory is not idle
//   mem_*_oe/out : memory-side drive, cache_*_oe/out : cache-side drive
interface main_mem_model_if
    import cache_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_MEM_ADDR_SIZE - DEFAULT_CACHE_OFFSET_SIZE,
    parameter int unsigned DATA_W = DEFAULT_BUS_SIZE
);
    logic [ADDR_W-1:0] mem_address;
    wire  [DATA_W-1:0] mem_data;
    wire  [1:0]        mem_command;
    logic              busy;

    logic              mem_cmd_oe;
    logic [1:0]        mem_cmd_out;
    logic              mem_data_oe;
    logic [DATA_W-1:0] mem_data_out;

    logic              cache_cmd_oe;
    logic [1:0]        cache_cmd_out;
    logic              cache_data_oe;
    logic [DATA_W-1:0] cache_data_out;

    assign mem_command = mem_cmd_oe    ? mem_cmd_out    : 'z;
    assign mem_command = cache_cmd_oe  ? cache_cmd_out  : 'z;
    assign mem_data    = mem_data_oe   ? mem_data_out   : 'z;
    assign mem_data    = cache_data_oe ? cache_data_out : 'z;

    modport master (
        output mem_address, cache_cmd_oe, cache_cmd_out, cache_data_oe, cache_data_out,
        input  mem_data, mem_command, busy
    );

    modport slave (
        input  mem_address, mem_data, mem_command,
        output busy, mem_cmd_oe, mem_cmd_out, mem_data_oe, mem_data_out
    );

endinterface

// File: rtl/main_mem_array.sv
// Line storage for main memory: 2^ADDR_W lines of WORDS x WORD_W bits.
// One line-wide synchronous write port, one asynchronous line read port.
// Power-up image: word k of line a = (a*WORDS + k) truncated to WORD_W.
// Lines never written return the image computed on the fly; a per-line flag selects
// the stored copy once a line has been written.
//   clk, we, waddr, wdata : write port
//   raddr, rdata          : read port
module main_mem_array #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [WORD_W*WORDS-1:0]  wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [WORD_W*WORDS-1:0]  rdata
);
    localparam int unsigned LINE_W = WORD_W * WORDS;
    localparam int unsigned LINES  = 2 ** ADDR_W;

    logic [LINE_W-1:0] mem_q [LINES];
    logic [LINES-1:0]  written_q = '0;

    function automatic logic [LINE_W-1:0] boot_line(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            l[k*WORD_W +: WORD_W] = WORD_W'(a * WORDS + k);
        end
        return l;
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr]     <= wdata;
            written_q[waddr] <= 1'b1;
        end
    end

    assign rdata = written_q[raddr] ? mem_q[raddr] : boot_line(raddr);

endmodule

// File: rtl/main_mem_model.sv
// Main-memory target on the C2 bus. Serves line READ/WRITE commands with a fixed
// latency L = max(MEM_LATENCY, 8), moving a line as BEATS beats of BUS_SIZE bits.
//   clk   : clock
//   reset : asynchronous, active-high; aborts any transfer, array is retained
//   bus   : C2 bus, slave side (address, shared data/command, busy)
module main_mem_model
    import cache_bus_pkg::*;
#(
    parameter int unsigned BUS_SIZE          = DEFAULT_BUS_SIZE,
    parameter int unsigned MEM_ADDR_SIZE     = DEFAULT_MEM_ADDR_SIZE,
    parameter int unsigned CACHE_OFFSET_SIZE = DEFAULT_CACHE_OFFSET_SIZE,
    parameter int unsigned CACHE_LINE_SIZE   = DEFAULT_CACHE_LINE_SIZE,
    parameter int unsigned MEM_LATENCY       = 100
) (
    input logic           clk,
    input logic           reset,
    main_mem_model_if.slave bus
);
    localparam int unsigned ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;
    localparam int unsigned BEATS  = LINE_W / BUS_SIZE;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned LAT    = (MEM_LATENCY < 8) ? 8 : MEM_LATENCY;
    localparam int unsigned CNT_W  = ($clog2(MEM_LATENCY + 8) > 8) ? $clog2(MEM_LATENCY + 8) : 8;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LAT - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    mem_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   line_ins;
    logic [LINE_W-1:0]   rd_line;
    logic                arr_we;

    main_mem_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (BUS_SIZE),
        .WORDS  (BEATS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (addr_q),
        .wdata (line_ins),
        .raddr (addr_q),
        .rdata (rd_line)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        line_d   = line_q;
        arr_we   = 1'b0;
        // Current write beat merged into the line, so the last beat commits in its own cycle.
        line_ins = line_q;
        line_ins[beat_q*BUS_SIZE +: BUS_SIZE] = bus.mem_data;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_command == C2Read) begin
                    addr_d  = bus.mem_address;
                    cnt_d   = CNT_LOAD;
                    beat_d  = '0;
                    state_d = StRdWait;
                end else if (bus.mem_command == C2Write) begin
                    addr_d  = bus.mem_address;
                    cnt_d   = CNT_LOAD;
                    line_d  = '0;
                    line_d[BUS_SIZE-1:0] = bus.mem_data;
                    beat_d  = BEAT_W'(1);
                    state_d = StWrData;
                end
            end
            StRdWait: begin
                if (cnt_q == '0) state_d = StRdBurst;
            end
            StRdBurst: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = StIdle;
            end
            StWrData: begin
                line_d = line_ins;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    arr_we  = 1'b1;
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                if (cnt_q == '0) state_d = StWrResp;
            end
            StWrResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // Drives decode only registered state, so the buses move just after a posedge and
    // release immediately on reset.
    assign bus.mem_cmd_oe   = (state_q == StRdBurst) || (state_q == StWrResp);
    assign bus.mem_cmd_out  = C2Response;
    assign bus.mem_data_oe  = (state_q == StRdBurst);
    assign bus.mem_data_out = rd_line[beat_q*BUS_SIZE +: BUS_SIZE];
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_main_mem_model.sv
// Directed bench for main_mem_model: one DUT at MEM_LATENCY=100, one at MEM_LATENCY=3.
// Captured per cycle: {cmd_oe, data_oe, busy, cmd (if driven), data (if driven)}.
module tb_main_mem_model;
    import cache_bus_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [20:0] cap  [128];
    logic [20:0] cap2 [128];

    main_mem_model_if bus ();
    main_mem_model_if bus2 ();

    main_mem_model #(.MEM_LATENCY(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    main_mem_model #(.MEM_LATENCY(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic cmd_oe, input logic [1:0] cmd, input logic [14:0] addr,
                         input logic data_oe, input logic [15:0] data);
        bus.cache_cmd_oe    = cmd_oe;
        bus.cache_cmd_out   = cmd;
        bus.mem_address     = addr;
        bus.cache_data_oe   = data_oe;
        bus.cache_data_out  = data;
        bus2.cache_cmd_oe   = cmd_oe;
        bus2.cache_cmd_out  = cmd;
        bus2.mem_address    = addr;
        bus2.cache_data_oe  = data_oe;
        bus2.cache_data_out = data;
    endtask

    // Issues cmd at the next posedge T (call at a negedge), then captures n cycles,
    // sample j taken mid-cycle after posedge T+j. spur_cyc injects a WRITE on bus only.
    task automatic run_txn(input logic [1:0] cmd, input logic [14:0] addr,
                           input logic [15:0] wbase, input int n, input int spur_cyc);
        logic is_wr;
        is_wr = (cmd == C2Write);
        drive(1'b1, cmd, addr, is_wr, wbase);
        @(posedge clk);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cap[j]  = {bus.mem_cmd_oe, bus.mem_data_oe, bus.busy,
                       bus.mem_cmd_oe ? bus.mem_command : 2'b00,
                       bus.mem_data_oe ? bus.mem_data : 16'h0000};
            cap2[j] = {bus2.mem_cmd_oe, bus2.mem_data_oe, bus2.busy,
                       bus2.mem_cmd_oe ? bus2.mem_command : 2'b00,
                       bus2.mem_data_oe ? bus2.mem_data : 16'h0000};
            drive(1'b0, C2Nop, addr, is_wr && (j < 7), wbase + 16'(j + 1));
            if (j + 1 == spur_cyc) begin
                bus.cache_cmd_oe   = 1'b1;
                bus.cache_cmd_out  = C2Write;
                bus.mem_address    = 15'h0012;
                bus.cache_data_oe  = 1'b1;
                bus.cache_data_out = 16'hDEAD;
            end
        end
        drive(1'b0, C2Nop, '0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        logic [2:0] got;
        reset = 1'b1;
        drive(1'b0, C2Nop, '0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        got = {bus.mem_cmd_oe, bus.mem_data_oe, bus.busy};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=000", got);
        end
        got = {bus2.mem_cmd_oe, bus2.mem_data_oe, bus2.busy};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state_lat3 got=%b exp=000", got);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        got = {bus.mem_cmd_oe, bus.mem_data_oe, bus.busy};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b exp=000", got);
        end
    endtask

    task automatic test_read();
        logic [20:0] exp;
        logic        oe;
        run_txn(C2Read, 15'h0012, 16'h0, 110, -1);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'h0090 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL read_0012 cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_write();
        logic [20:0] exp;
        logic        oe;
        run_txn(C2Write, 15'h0012, 16'hA000, 103, -1);
        for (int j = 0; j < 103; j++) begin
            oe  = (j == 100);
            exp = {oe, 1'b0, 1'(j < 101), oe ? 2'b01 : 2'b00, 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL write_resp cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
        run_txn(C2Read, 15'h0012, 16'h0, 110, -1);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'hA000 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL raw_readback cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_read_top();
        logic [20:0] exp;
        logic        oe;
        run_txn(C2Read, 15'h7FFF, 16'h0, 110, -1);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'hFFF8 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL read_7fff cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_spurious();
        logic [20:0] exp;
        logic        oe;
        run_txn(C2Read, 15'h0012, 16'h0, 110, 30);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'hA000 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL spurious_write cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_reset_rd_wait();
        logic [20:0] exp;
        logic [2:0]  got;
        logic        oe;
        run_txn(C2Read, 15'h0005, 16'h0, 50, -1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 got = {bus.mem_cmd_oe, bus.mem_data_oe, bus.busy};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_in_rd_wait got=%b exp=000", got);
        end
        @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        // Aborted read would have answered 40 cycles into this window.
        run_txn(C2Read, 15'h0005, 16'h0, 110, -1);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'h0028 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL read_after_reset cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_reset_wr_data();
        logic [20:0] exp;
        logic [2:0]  got;
        logic        oe;
        bus.mem_address    = 15'h0033;
        bus.cache_cmd_out  = C2Write;
        bus.cache_cmd_oe   = 1'b1;
        bus.cache_data_out = 16'h5000;
        bus.cache_data_oe  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.cache_cmd_oe   = 1'b0;
            bus.cache_data_out = 16'h5000 + 16'(k);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 got = {bus.mem_cmd_oe, bus.mem_data_oe, bus.busy};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_in_wr_data got=%b exp=000", got);
        end
        bus.cache_data_oe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn(C2Read, 15'h0033, 16'h0, 110, -1);
        for (int j = 0; j < 110; j++) begin
            oe  = (j >= 100) && (j < 108);
            exp = {oe, oe, 1'(j < 108), oe ? 2'b01 : 2'b00, oe ? 16'h0198 + 16'(j - 100) : 16'h0};
            vectors++;
            if (cap[j] !== exp) begin
                miscompares++;
                $display("FAIL no_commit_after_reset cyc=%0d got=%h exp=%h", j, cap[j], exp);
            end
        end
    endtask

    task automatic test_min_latency();
        logic [20:0] exp;
        logic        oe;
        run_txn(C2Write, 15'h0100, 16'hB000, 12, -1);
        for (int j = 0; j < 12; j++) begin
            oe  = (j == 8);
            exp = {oe, 1'b0, 1'(j < 9), oe ? 2'b01 : 2'b00, 16'h0};
            vectors++;
            if (cap2[j] !== exp) begin
                miscompares++;
                $display("FAIL lat3_write cyc=%0d got=%h exp=%h", j, cap2[j], exp);
            end
        end
        run_txn(C2Read, 15'h0100, 16'h0, 18, -1);
        for (int j = 0; j < 18; j++) begin
            oe  = (j >= 8) && (j < 16);
            exp = {oe, oe, 1'(j < 16), oe ? 2'b01 : 2'b00, oe ? 16'hB000 + 16'(j - 8) : 16'h0};
            vectors++;
            if (cap2[j] !== exp) begin
                miscompares++;
                $display("FAIL lat3_read cyc=%0d got=%h exp=%h", j, cap2[j], exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_read();
        test_write();
        test_read_top();
        test_spurious();
        test_reset_rd_wait();
        test_reset_wr_data();
        test_min_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
